// File: rtl/bcd_serial_adder_ctrl.sv
// bcd_serial_adder_ctrl
//
// Digit-serial packed-BCD adder controller. Two N-digit operands are latched
// on an accepted start and summed one decimal digit per clock, least
// significant digit first, through a single 4-bit BCD digit slice. The
// inter-digit carry is registered. The result, carry-out and an
// invalid-digit flag are held from the done pulse until the next accepted
// start.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset (wins over everything, even mid-add)
//   start  operation request, sampled only in IDLE or DONE
//   a, b   packed BCD operands, digit i at [4i+3:4i]
//   cin    decimal carry into digit 0
//   busy   high while digits are being processed
//   done   one-cycle pulse, result valid
//   sum    packed BCD result
//   cout   decimal carry out of the most significant digit
//   err    an operand digit of the last operation was greater than 9

module bcd_serial_adder_ctrl #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [4*N-1:0] a,
    input  logic [4*N-1:0] b,
    input  logic           cin,
    output logic           busy,
    output logic           done,
    output logic [4*N-1:0] sum,
    output logic           cout,
    output logic           err
);

    localparam int CW = $clog2(N) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]     state_reg;
    logic [4*N-1:0] a_sh_reg;
    logic [4*N-1:0] b_sh_reg;
    logic [4*N-1:0] sum_reg;
    logic           carry_reg;
    logic [CW-1:0]  cnt_reg;
    logic           cout_reg;
    logic           err_reg;

    // Single digit slice.
    logic [3:0] x_digit;
    logic [3:0] y_digit;
    logic [4:0] raw_sum;
    logic       digit_carry;
    logic [3:0] digit_out;
    logic       digit_bad;

    assign x_digit     = a_sh_reg[3:0];
    assign y_digit     = b_sh_reg[3:0];
    assign raw_sum     = {1'b0, x_digit} + {1'b0, y_digit} + {4'd0, carry_reg};
    assign digit_carry = (raw_sum > 5'd9);
    // (raw + 6) mod 16 only needs the low nibble.
    assign digit_out   = digit_carry ? (raw_sum[3:0] + 4'd6) : raw_sum[3:0];
    assign digit_bad   = (x_digit > 4'd9) || (y_digit > 4'd9);

    // New digit enters at the MSB end; after N shifts digit 0 sits at [3:0].
    // Built per nibble so that N=1 needs no special slice handling.
    logic [4*N-1:0] sum_shift;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_sum_shift
            if (gi == N - 1) begin : g_top
                assign sum_shift[4*gi+3:4*gi] = digit_out;
            end else begin : g_mid
                assign sum_shift[4*gi+3:4*gi] = sum_reg[4*gi+7:4*gi+4];
            end
        end
    endgenerate

    logic last_digit;
    logic accept;

    assign last_digit = (cnt_reg == CW'(N - 1));
    assign accept     = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            cout_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= b;
                        carry_reg <= cin;
                        cnt_reg   <= '0;
                        err_reg   <= 1'b0;
                        sum_reg   <= '0;
                        state_reg <= ST_ADD;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_ADD: begin
                    sum_reg   <= sum_shift;
                    carry_reg <= digit_carry;
                    a_sh_reg  <= a_sh_reg >> 4;
                    b_sh_reg  <= b_sh_reg >> 4;
                    cnt_reg   <= cnt_reg + 1'b1;
                    err_reg   <= err_reg | digit_bad;
                    if (last_digit) begin
                        cout_reg  <= digit_carry;
                        state_reg <= ST_DONE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state_reg == ST_ADD);
    assign done = (state_reg == ST_DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign err  = err_reg;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Directed testbench for bcd_serial_adder_ctrl with N=4.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_bcd_serial_adder_ctrl;

    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic [4*N-1:0] a;
    logic [4*N-1:0] b;
    logic           cin;
    logic           busy;
    logic           done;
    logic [4*N-1:0] sum;
    logic           cout;
    logic           err;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_serial_adder_ctrl #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Full operation: accept, N busy cycles, done cycle with result checks.
    // scramble changes the operand inputs right after the accepting edge.
    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic ci, input logic scramble,
                          input logic [15:0] es, input logic ec, input logic ee);
        @(negedge clk);
        a = av; b = bv; cin = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (scramble) begin
            a = 16'h9999; b = 16'h9999; cin = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            check({tag, " busy/done in add"}, {30'd0, busy, done}, 32'b10);
            @(negedge clk);
        end
        check({tag, " busy/done at done"}, {30'd0, busy, done}, 32'b01);
        check({tag, " sum"}, {16'd0, sum}, {16'd0, es});
        check({tag, " cout"}, {31'd0, cout}, {31'd0, ec});
        check({tag, " err"}, {31'd0, err}, {31'd0, ee});
        $display("op %s: a=%h b=%h cin=%b -> sum=%h cout=%b err=%b", tag, av, bv, ci, sum, cout, err);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        check("reset outputs", {12'd0, busy, done, cout, err, sum}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle no start", {30'd0, busy, done}, 32'd0);
        $display("reset: busy=%b done=%b sum=%h cout=%b err=%b", busy, done, sum, cout, err);

        run_op("basic",   16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0);
        run_op("ripple",  16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("max",     16'h9999, 16'h9999, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0);
        run_op("bad_lo",  16'h000A, 16'h0000, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b1);
        run_op("valid",   16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
        run_op("bad_hi",  16'hA000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Held start: back-to-back operations, one per N+1 cycles.
        @(negedge clk);
        a = 16'h0005; b = 16'h0005; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) begin
                check("held busy in add", {30'd0, busy, done}, 32'b10);
                @(negedge clk);
            end
            check("held done", {30'd0, busy, done}, 32'b01);
            check("held sum", {16'd0, sum}, 32'h0010);
            $display("op held#%0d: a=0005 b=0005 -> sum=%h cout=%b", k, sum, cout);
            if (k == 2) start = 1'b0;
            @(negedge clk);
        end
        check("held back to idle", {30'd0, busy, done}, 32'd0);

        // Reset in the middle of an add discards the partial result.
        a = 16'h4321; b = 16'h1111; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("partial sum before reset", {16'd0, sum}, 32'h3200);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid reset outputs", {12'd0, busy, done, cout, err, sum}, 32'd0);
        @(negedge clk);
        check("after reset idle", {30'd0, busy, done}, 32'd0);
        $display("mid-add reset: busy=%b done=%b sum=%h cout=%b err=%b", busy, done, sum, cout, err);
        run_op("fresh",   16'h4321, 16'h1111, 1'b0, 1'b0, 16'h5432, 1'b0, 1'b0);

        // Operands changed after acceptance must not affect the result.
        run_op("latched", 16'h1234, 16'h5678, 1'b0, 1'b1, 16'h6912, 1'b0, 1'b0);

        // Result holds after done.
        @(negedge clk);
        check("hold sum after done", {16'd0, sum}, 32'h6912);
        check("idle after done", {30'd0, busy, done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
